// File: rtl/snake_engine_if.sv
// Snake engine control/status bundle: game inputs from the controller, body state back out.
// The master drives start/step/dir/apple; the slave (engine) drives everything else.
interface snake_engine_if #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int MAX_LEN = 128
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int NCELL = GRID_W * GRID_H;

  logic             start;
  logic             step;
  logic [1:0]       dir;
  logic [XW-1:0]    apple_x;
  logic [YW-1:0]    apple_y;
  logic [XW-1:0]    head_x;
  logic [YW-1:0]    head_y;
  logic [LW-1:0]    length;
  logic [1:0]       heading;
  logic             apple_eaten;
  logic             game_over;
  logic             busy;
  logic             done;
  logic [NCELL-1:0] occupancy;

  modport master (
    output start, step, dir, apple_x, apple_y,
    input  head_x, head_y, length, heading, apple_eaten, game_over, busy, done, occupancy
  );

  modport slave (
    input  start, step, dir, apple_x, apple_y,
    output head_x, head_y, length, heading, apple_eaten, game_over, busy, done, occupancy
  );
endinterface

// File: rtl/snake_engine.sv
// Snake game core: ring buffer of body coordinates plus occupancy map, one cell per step.
// Step latency 2 cycles (IDLE->CALC->COMMIT); steps arriving while busy or dead are dropped.
module snake_engine #(
  parameter int GRID_W         = 16,
  parameter int GRID_H         = 16,
  parameter int MAX_LEN        = 128,
  parameter int INIT_LEN       = 3,
  parameter int WRAP           = 0,
  parameter int GROW_PER_APPLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  snake_engine_if.slave bus
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int PW    = $clog2(MAX_LEN);
  localparam int NCELL = GRID_W * GRID_H;
  localparam int CW    = $clog2(NCELL);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [YW-1:0] Y_INIT = YW'(GRID_H / 2);

  function automatic logic [NCELL-1:0] init_occ();
    logic [NCELL-1:0] r;
    r = '0;
    for (int i = 0; i < INIT_LEN; i++) r[(GRID_H / 2) * GRID_W + i] = 1'b1;
    return r;
  endfunction

  localparam logic [NCELL-1:0] OCC_INIT = init_occ();

  function automatic logic [CW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return CW'(int'(y) * GRID_W + int'(x));
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_COMMIT, S_DEAD} state_t;

  state_t           state_q;
  logic [XW-1:0]    ring_x_q [MAX_LEN];
  logic [YW-1:0]    ring_y_q [MAX_LEN];
  logic [PW-1:0]    head_ptr_q, tail_ptr_q;
  logic [XW-1:0]    head_x_q;
  logic [YW-1:0]    head_y_q;
  logic [LW-1:0]    length_q;
  logic [1:0]       heading_q, dir_q;
  logic [3:0]       pend_q;
  logic [NCELL-1:0] occ_q;
  logic             go_q, busy_q, done_q, eaten_q;

  // Move evaluation captured at the end of CALC and applied in COMMIT.
  logic [XW-1:0]    nx_q;
  logic [YW-1:0]    ny_q;
  logic [1:0]       nd_q;
  logic             die_q, grow_q, hit_q, full_q;

  logic [XW-1:0]    nx_d, tail_x;
  logic [YW-1:0]    ny_d, tail_y;
  logic [1:0]       nd_d;
  logic             wall_d, hit_d, grow_d, die_d, full_d, tail_hit;
  logic [PW-1:0]    head_ptr_inc, tail_ptr_inc;
  logic [4:0]       pend_sum;
  logic [3:0]       pend_d;

  always_comb begin
    nd_d   = (dir_q == (heading_q ^ 2'b01)) ? heading_q : dir_q;
    nx_d   = head_x_q;
    ny_d   = head_y_q;
    wall_d = 1'b0;
    case (nd_d)
      DIR_UP: begin
        if (head_y_q == '0) begin
          if (WRAP != 0) ny_d = YW'(GRID_H - 1);
          else           wall_d = 1'b1;
        end else ny_d = head_y_q - 1'b1;
      end
      DIR_DOWN: begin
        if (head_y_q == YW'(GRID_H - 1)) begin
          if (WRAP != 0) ny_d = '0;
          else           wall_d = 1'b1;
        end else ny_d = head_y_q + 1'b1;
      end
      DIR_LEFT: begin
        if (head_x_q == '0) begin
          if (WRAP != 0) nx_d = XW'(GRID_W - 1);
          else           wall_d = 1'b1;
        end else nx_d = head_x_q - 1'b1;
      end
      default: begin
        if (head_x_q == XW'(GRID_W - 1)) begin
          if (WRAP != 0) nx_d = '0;
          else           wall_d = 1'b1;
        end else nx_d = head_x_q + 1'b1;
      end
    endcase

    tail_x   = ring_x_q[tail_ptr_q];
    tail_y   = ring_y_q[tail_ptr_q];
    hit_d    = (nx_d == bus.apple_x) && (ny_d == bus.apple_y);
    full_d   = (length_q == LW'(MAX_LEN));
    grow_d   = (hit_d || (pend_q != 4'd0)) && !full_d;
    tail_hit = (nx_d == tail_x) && (ny_d == tail_y);
    // On a wall hit the coordinates stay at the head, whose own bit is set, so die_d holds either way.
    die_d    = wall_d || (occ_q[cell_idx(nx_d, ny_d)] && !(tail_hit && !grow_d));

    head_ptr_inc = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + 1'b1;
    tail_ptr_inc = (tail_ptr_q == PW'(MAX_LEN - 1)) ? '0 : tail_ptr_q + 1'b1;

    pend_sum = {1'b0, pend_q} + 5'(GROW_PER_APPLE - 1);
    if (full_q)      pend_d = 4'd0;
    else if (hit_q)  pend_d = (pend_sum > 5'd15) ? 4'hF : pend_sum[3:0];
    else if (grow_q) pend_d = pend_q - 4'd1;
    else             pend_d = pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        ring_x_q[i] <= (i < INIT_LEN) ? XW'(i) : '0;
        ring_y_q[i] <= Y_INIT;
      end
      state_q    <= S_IDLE;
      head_ptr_q <= PW'(INIT_LEN - 1);
      tail_ptr_q <= '0;
      head_x_q   <= XW'(INIT_LEN - 1);
      head_y_q   <= Y_INIT;
      length_q   <= LW'(INIT_LEN);
      heading_q  <= DIR_RIGHT;
      dir_q      <= DIR_RIGHT;
      pend_q     <= 4'd0;
      occ_q      <= OCC_INIT;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eaten_q    <= 1'b0;
      nx_q       <= '0;
      ny_q       <= '0;
      nd_q       <= DIR_RIGHT;
      die_q      <= 1'b0;
      grow_q     <= 1'b0;
      hit_q      <= 1'b0;
      full_q     <= 1'b0;
    end else if (bus.start) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        ring_x_q[i] <= (i < INIT_LEN) ? XW'(i) : '0;
        ring_y_q[i] <= Y_INIT;
      end
      state_q    <= S_IDLE;
      head_ptr_q <= PW'(INIT_LEN - 1);
      tail_ptr_q <= '0;
      head_x_q   <= XW'(INIT_LEN - 1);
      head_y_q   <= Y_INIT;
      length_q   <= LW'(INIT_LEN);
      heading_q  <= DIR_RIGHT;
      dir_q      <= DIR_RIGHT;
      pend_q     <= 4'd0;
      occ_q      <= OCC_INIT;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eaten_q    <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      eaten_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.step && !go_q) begin
            dir_q   <= bus.dir;
            busy_q  <= 1'b1;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          nx_q    <= nx_d;
          ny_q    <= ny_d;
          nd_q    <= nd_d;
          die_q   <= die_d;
          grow_q  <= grow_d;
          hit_q   <= hit_d;
          full_q  <= full_d;
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (die_q) begin
            go_q    <= 1'b1;
            state_q <= S_DEAD;
          end else begin
            ring_x_q[head_ptr_inc] <= nx_q;
            ring_y_q[head_ptr_inc] <= ny_q;
            head_ptr_q <= head_ptr_inc;
            head_x_q   <= nx_q;
            head_y_q   <= ny_q;
            heading_q  <= nd_q;
            pend_q     <= pend_d;
            eaten_q    <= hit_q;
            if (grow_q) begin
              length_q <= length_q + 1'b1;
            end else begin
              occ_q[cell_idx(ring_x_q[tail_ptr_q], ring_y_q[tail_ptr_q])] <= 1'b0;
              tail_ptr_q <= tail_ptr_inc;
            end
            // Set after the tail clear so a head entering the vacated tail cell keeps its bit.
            occ_q[cell_idx(nx_q, ny_q)] <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.head_x      = head_x_q;
  assign bus.head_y      = head_y_q;
  assign bus.length      = length_q;
  assign bus.heading     = heading_q;
  assign bus.apple_eaten = eaten_q;
  assign bus.game_over   = go_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.occupancy   = occ_q;
endmodule

// File: tb/tb_snake_engine.sv
// Directed bench for snake_engine: three instances (walls, growth 3, wrap) share one stimulus stream.
module tb_snake_engine;
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       step  = 1'b0;
  logic [1:0] dir   = 2'b11;
  logic [3:0] ax    = 4'd9;
  logic [3:0] ay    = 4'd9;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  snake_engine_if if0 ();
  snake_engine_if if1 ();
  snake_engine_if if2 ();

  assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
  assign if0.step  = step;   assign if1.step  = step;   assign if2.step  = step;
  assign if0.dir   = dir;    assign if1.dir   = dir;    assign if2.dir   = dir;
  assign if0.apple_x = ax;   assign if1.apple_x = ax;   assign if2.apple_x = ax;
  assign if0.apple_y = ay;   assign if1.apple_y = ay;   assign if2.apple_y = ay;

  snake_engine #(.WRAP(0), .GROW_PER_APPLE(1)) u_wall (.clk(clk), .rst_n(rst_n), .bus(if0));
  snake_engine #(.WRAP(0), .GROW_PER_APPLE(3)) u_grow (.clk(clk), .rst_n(rst_n), .bus(if1));
  snake_engine #(.WRAP(1), .GROW_PER_APPLE(1)) u_wrap (.clk(clk), .rst_n(rst_n), .bus(if2));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] bit_at(input int i);
    logic [255:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk_rst(input string t);
    chk({t, ".hx"},   if0.head_x, 2);
    chk({t, ".hy"},   if0.head_y, 8);
    chk({t, ".len"},  if0.length, 3);
    chk({t, ".hdg"},  if0.heading, 2'b11);
    chk({t, ".occ"},  if0.occupancy, bit_at(128) | bit_at(129) | bit_at(130));
    chk({t, ".busy"}, if0.busy, 0);
    chk({t, ".done"}, if0.done, 0);
    chk({t, ".go"},   if0.game_over, 0);
  endtask

  // Leaves the caller at the falling edge just after the accepting rising edge.
  task automatic pulse_step(input logic [1:0] d);
    @(negedge clk);
    dir  = d;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Leaves the caller at the falling edge where done is expected.
  task automatic do_step(input logic [1:0] d);
    pulse_step(d);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk_rst("t1");

    // Single right step, with a second request during busy that must be dropped.
    ax = 4'd9; ay = 4'd9;
    pulse_step(2'b11);
    chk("t2.busy_a", if0.busy, 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    chk("t2.busy_b", if0.busy, 1);
    chk("t2.done_b", if0.done, 0);
    @(negedge clk);
    chk("t2.done", if0.done, 1);
    chk("t2.busy_c", if0.busy, 0);
    chk("t2.hx", if0.head_x, 3);
    chk("t2.hy", if0.head_y, 8);
    chk("t2.len", if0.length, 3);
    chk("t2.occ", if0.occupancy, bit_at(129) | bit_at(130) | bit_at(131));
    @(negedge clk);
    chk("t2.done_pulse", if0.done, 0);
    chk("t2.drop", if0.busy, 0);

    // Reverse request keeps heading; then turn up.
    do_step(2'b10);
    chk("t3.hx", if0.head_x, 4);
    chk("t3.hy", if0.head_y, 8);
    chk("t3.hdg", if0.heading, 2'b11);
    do_step(2'b00);
    chk("t3.up_hx", if0.head_x, 4);
    chk("t3.up_hy", if0.head_y, 7);
    chk("t3.up_hdg", if0.heading, 2'b00);
    chk("t3.up_occ", if0.occupancy, bit_at(131) | bit_at(132) | bit_at(116));

    // Eating, and multi-segment growth on the GROW_PER_APPLE=3 instance.
    do_start();
    chk_rst("t4.start");
    ax = 4'd3; ay = 4'd8;
    do_step(2'b11);
    chk("t4.eaten", if0.apple_eaten, 1);
    chk("t4.len0", if0.length, 4);
    chk("t4.occ0", if0.occupancy, bit_at(128) | bit_at(129) | bit_at(130) | bit_at(131));
    chk("t4.len1_a", if1.length, 4);
    @(negedge clk);
    chk("t4.eaten_pulse", if0.apple_eaten, 0);
    ax = 4'd9; ay = 4'd9;
    do_step(2'b11);
    chk("t4.len0_b", if0.length, 4);
    chk("t4.len1_b", if1.length, 5);
    do_step(2'b11);
    chk("t4.len1_c", if1.length, 6);
    do_step(2'b11);
    chk("t4.len1_d", if1.length, 6);
    chk("t4.hx1", if1.head_x, 6);
    chk("t4.occ1", if1.occupancy, bit_at(129) | bit_at(130) | bit_at(131) |
                                  bit_at(132) | bit_at(133) | bit_at(134));
    chk("t4.occ0_d", if0.occupancy, bit_at(131) | bit_at(132) | bit_at(133) | bit_at(134));

    // Wall versus wrap at the right edge.
    do_start();
    for (int i = 0; i < 13; i++) do_step(2'b11);
    chk("t5.hx_edge", if0.head_x, 15);
    chk("t5.go_pre", if0.game_over, 0);
    do_step(2'b11);
    chk("t5.go", if0.game_over, 1);
    chk("t5.done", if0.done, 1);
    chk("t5.hx", if0.head_x, 15);
    chk("t5.len", if0.length, 3);
    chk("t5.go1", if1.game_over, 1);
    chk("t5.wrap_hx", if2.head_x, 0);
    chk("t5.wrap_go", if2.game_over, 0);
    chk("t5.wrap_occ", if2.occupancy, bit_at(142) | bit_at(143) | bit_at(128));
    pulse_step(2'b11);
    chk("t5.dead_busy", if0.busy, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t5.dead_done", if0.done, 0);
    chk("t5.dead_hx", if0.head_x, 15);
    chk("t5.wrap_hx2", if2.head_x, 1);
    do_start();
    chk_rst("t5.restart");
    chk("t5.go1_clr", if1.game_over, 0);

    // Head enters the cell the tail is vacating: legal.
    do_start();
    ax = 4'd3; ay = 4'd8;
    do_step(2'b11);
    ax = 4'd9; ay = 4'd9;
    do_step(2'b01);
    do_step(2'b10);
    chk("t6a.go_mid", if0.game_over, 0);
    do_step(2'b00);
    chk("t6a.go", if0.game_over, 0);
    chk("t6a.hx", if0.head_x, 2);
    chk("t6a.hy", if0.head_y, 8);
    chk("t6a.len", if0.length, 4);
    chk("t6a.occ", if0.occupancy, bit_at(130) | bit_at(131) | bit_at(146) | bit_at(147));
    chk("t6a.go1", if1.game_over, 1);

    // Same loop, but eating on the tail cell keeps the tail: collision.
    do_start();
    ax = 4'd3; ay = 4'd8;
    do_step(2'b11);
    ax = 4'd9; ay = 4'd9;
    do_step(2'b01);
    do_step(2'b10);
    ax = 4'd2; ay = 4'd8;
    do_step(2'b00);
    chk("t6b.go", if0.game_over, 1);
    chk("t6b.hx", if0.head_x, 2);
    chk("t6b.hy", if0.head_y, 9);
    chk("t6b.len", if0.length, 4);
    chk("t6b.eaten", if0.apple_eaten, 0);

    // Asynchronous reset while the engine sits in CALC.
    do_start();
    ax = 4'd9; ay = 4'd9;
    do_step(2'b11);
    chk("t6c.hx_pre", if0.head_x, 3);
    pulse_step(2'b11);
    chk("t6c.busy_pre", if0.busy, 1);
    rst_n = 1'b0;
    #1;
    chk_rst("t6c.rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6c.done_after", if0.done, 0);
    chk("t6c.hx_after", if0.head_x, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/snake_engine.md
Name: snake_engine

Overview:
- Parametrised snake game core for the LED-matrix game, generalising the fixed 16x16, 128-segment snake logic.
- Configurable in grid size, maximum length, wall or wrap-around mode, and growth per apple.
- Holds the body as a circular coordinate buffer plus a per-cell occupancy map, and advances one cell per step request through a two-stage FSM.
- Apple generation and the display mapping sit outside; occupancy feeds the pixel arrays and head/eaten feed the apple generator and score logic.

Parameters:
- GRID_W, 16: grid columns. XW = clog2(GRID_W).
- GRID_H, 16: grid rows. YW = clog2(GRID_H).
- MAX_LEN, 128: ring buffer depth and maximum snake length. LW = clog2(MAX_LEN+1).
- INIT_LEN, 3: length after reset/start. Constraint: 2 <= INIT_LEN <= min(GRID_W, MAX_LEN).
- WRAP, 0: 0 = edges are walls; 1 = head wraps to the opposite edge.
- GROW_PER_APPLE, 1: segments added per apple, range 1..15.

Ports:
- clk, input, 1: single clock; all state on its rising edge.
- rst, input, 1: asynchronous active-low reset (asserted at 0).
- start, input, 1: one-cycle pulse; re-initialises the game.
- step, input, 1: one-cycle pulse; request one move.
- dir, input, 2: requested heading. 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- apple_x, input, XW: apple column.
- apple_y, input, YW: apple row.
- head_x, output, XW: current head column.
- head_y, output, YW: current head row.
- length, output, LW: current segment count.
- heading, output, 2: committed heading.
- apple_eaten, output, 1: one-cycle pulse when the head lands on the apple.
- game_over, output, 1: sticky collision flag.
- busy, output, 1: high while a step is in flight.
- done, output, 1: one-cycle pulse when a step completes.
- occupancy, output, GRID_W*GRID_H: bit y*GRID_W+x is set iff a segment occupies (x,y).

Behaviour:
- Reset and start load the same state:
  - Body cells are (0..INIT_LEN-1, GRID_H/2); tail at x=0, head at x=INIT_LEN-1.
  - heading = right, length = INIT_LEN, pending growth = 0.
  - game_over, busy, done, apple_eaten = 0; state = IDLE.
  - occupancy holds exactly those INIT_LEN bits.
  - start is synchronous, takes one cycle, is honoured in any state, and beats step in the same cycle.
- States:
  - IDLE: step with game_over=0 latches dir and moves to CALC; busy=1 from the next cycle.
  - CALC:
    - Effective heading = latched dir, unless it is the exact reverse of heading, in which case heading is kept.
    - nx/ny = head moved one cell.
    - WRAP=0: leaving 0..GRID_W-1 or 0..GRID_H-1 is a wall hit. WRAP=1: coordinate becomes modulo GRID_W/GRID_H.
    - hit = (nx,ny)==(apple_x,apple_y).
    - grow = hit or pending>0. At length==MAX_LEN, grow is forced to 0 and pending cleared.
    - Self-collision = occupancy at (nx,ny) set, except the tail cell when grow=0 (the tail vacates that step).
  - COMMIT:
    - On wall hit or self-collision: game_over=1, body/heading/length unchanged, go to DEAD.
    - Otherwise:
      - Write the new head into the ring and set its occupancy bit; update heading.
      - If grow=0: clear the tail occupancy bit and advance the tail pointer.
      - If grow=1: length+1 and the tail is unchanged.
      - pending becomes pending+GROW_PER_APPLE-1 on a hit, pending-1 on a growth without a hit. Saturate at 15.
      - apple_eaten=1 on a hit, including at MAX_LEN.
    - Either way: done=1 for one cycle, busy=0, return to IDLE (or DEAD).
  - DEAD: all step pulses ignored; only start exits.
- Latency:
  - step accepted at edge t; CALC at t+1; outputs, occupancy and done valid after edge t+2.
  - busy is high for the two cycles after edge t.
  - step while busy or game_over is dropped, with no done pulse.
- Ring pointers wrap modulo MAX_LEN, so MAX_LEN need not be a power of two.
- Apple coordinates outside the grid never match.
- rst asserted mid-step aborts the step immediately into the reset state; no partial occupancy update is visible.

Test Plan:
1. Reset (defaults) -> head (2,8), length 3, heading 11, occupancy bits 128,129,130 only, busy/done/game_over 0.
2. Apple at (9,9), dir=11, one step -> busy high 2 cycles; then head (3,8), bit 128 clear, bit 131 set, length 3, done one pulse. A second step during busy -> ignored.
3. dir=10 (reverse) while heading right, step -> head (4,8), heading stays 11. Then dir=00, step -> head (4,7).
4. Apple at (3,8), step from (2,8) -> apple_eaten pulse, length 4, tail bit 128 kept. Repeat with GROW_PER_APPLE=3 -> length grows on 3 consecutive steps, then stays constant.
5. WRAP=0: 13 right steps from reset reach (15,8), next step -> game_over=1, head stays (15,8), further steps produce no done. start -> reset pattern. WRAP=1: same step -> head (0,8), no game_over.
6. Length 4, move down/left/up so the head enters the cell the tail vacates -> no collision. Same loop one step after eating -> game_over. Also pull rst low during CALC -> reset values immediately.
